mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  - Load/store front end between ALU result/register operands and data_memory (word-wide, WE-only).
//  - Adds byte/halfword/word loads with sign/zero extension, little-endian.
//  - Sub-word stores are done as a 2-cycle read-modify-write, because data_memory has no byte enables.
//  - Issues a registered response and stalls the requester via req_ready during RMW.
// PARAMETERS
//  - ADDR_WIDTH  32  byte-address width of req_addr and mem_addr
//  - DATA_WIDTH  32  data width; fixed at 32 (byte lanes addr[1:0])
// PORTS
//  - clock       in   1           single clock, all state on posedge
//  - reset       in   1           synchronous, active-high
//  - req_valid   in   1           request present
//  - req_ready   out  1           1 = request accepted this cycle (state IDLE)
//  - req_write   in   1           1 = store, 0 = load
//  - req_size    in   2           00 byte, 01 half, 10 word, 11 reserved (treated as word)
//  - req_signed  in   1           loads: 1 = sign-extend, 0 = zero-extend
//  - req_addr    in   ADDR_WIDTH  byte address (ALU result)
//  - req_wdata   in   DATA_WIDTH  store data, right-justified
//  - resp_valid  out  1           1-cycle pulse, request completed
//  - resp_rdata  out  DATA_WIDTH  load result (0 for stores/errors)
//  - resp_err    out  1           misaligned request (see CONFIGURATION)
//  - mem_we      out  1           to data_memory WE
//  - mem_addr    out  ADDR_WIDTH  word index = {2'b00, addr[ADDR_WIDTH-1:2]}
//  - mem_wdata   out  DATA_WIDTH  to data_memory WriteData
//  - mem_rdata   in   DATA_WIDTH  data_memory ReadData (combinational read)
// BEHAVIOUR
//  - Clocking/reset: one clock, reset synchronous active-high.
//  - Reset values: state=IDLE, resp_valid=0, resp_rdata=0, resp_err=0, captured regs=0; mem_we=0 while reset=1.
//  - States: IDLE, RMW_WR. req_ready = (state==IDLE). Accept = req_valid & req_ready.
//  - mem_addr/mem_wdata/mem_we are combinational.
//    - IDLE: mem_addr from req_addr.
//    - RMW_WR: mem_addr from the captured address.
//  - Load (accept, !req_write): read mem_rdata same cycle and select the lane.
//    - byte: addr[1:0]*8.
//    - half: addr[1]*16.
//    - Extend per req_signed.
//    - Register into resp_rdata; resp_valid=1 next cycle. Latency 1. Stay IDLE.
//  - Word store: mem_we=1 same cycle, mem_wdata=req_wdata; resp_valid next cycle. Stay IDLE.
//  - Sub-word store:
//    - Accept cycle: capture mem_rdata, addr, size and wdata; mem_we=0; go to RMW_WR.
//    - RMW_WR: mem_we=1, mem_wdata = old word with the target lane replaced by wdata[7:0] or wdata[15:0].
//    - Return to IDLE; resp_valid the cycle after RMW_WR. Latency 2; req_ready=0 during RMW_WR.
//  - resp_valid is high for exactly 1 cycle per accepted request; at most 1 request in flight.
//  - Stores: resp_rdata=0.
//  - Back-to-back requests: accepted every cycle in IDLE (loads, word stores). A load right after a
//    word store to the same word sees the new data, because memory writes on posedge.
//  - req_valid while req_ready=0: ignored (the requester must hold the request).
//  - Reset during RMW_WR takes priority: mem_we=0, the write is dropped, and no resp_valid follows.
//  - Address wrap: the top two bits of mem_addr are always 0; no overflow handling needed.
// CONFIGURATION
//  - MAU_MISALIGN_TRAP_EN defined:
//    - half with addr[0]=1, or word with addr[1:0]!=0: no memory access (mem_we=0, no RMW).
//    - Next cycle: resp_valid=1, resp_err=1, resp_rdata=0.
//  - Undefined: low address bits are forced to the natural alignment (half: addr[0]=0;
//    word: addr[1:0]=0), the access proceeds normally, and resp_err is tied 0.
// TESTING
//  - Word store then load:
//    - Stimulus: store word 0xDEADBEEF @0x10, then load word signed @0x10.
//    - Expect: mem_we 1 cycle, mem_addr=4; load resp_rdata=0xDEADBEEF, 1 cycle after accept.
//  - Byte RMW store:
//    - Stimulus: mem word 4 = 0x11223344; store byte 0xAA @0x12.
//    - Expect: req_ready low 1 cycle, mem_wdata=0x11AA3344, resp_valid 2 cycles after accept.
//  - Sign/zero extension:
//    - Stimulus: word 0x8000FF80; load byte @0x0, signed then unsigned.
//    - Expect: 0xFFFFFF80 / 0x00000080.
//    - Stimulus: load half @0x2, signed.
//    - Expect: 0xFFFF8000.
//  - Misaligned:
//    - Stimulus: load word @0x13.
//    - Expect with MAU_MISALIGN_TRAP_EN: resp_err=1, rdata=0, no mem_we.
//    - Expect without: reads word 4, resp_err=0.
//  - Reset mid-RMW:
//    - Stimulus: store half 0xBEEF @0x2, assert reset during RMW_WR.
//    - Expect: mem_we=0, word 0 unchanged, resp_valid=0, req_ready=1 after reset.
//  - Back-to-back:
//    - Stimulus: 3 word loads on consecutive cycles.
//    - Expect: req_ready stays 1, 3 consecutive resp_valid pulses, data in order.

Source files
------------

// File: rtl/mem_access_unit.sv
// Purpose: load/store front end for a word-wide data_memory without byte enables; sub-word stores use read-modify-write.
// Latency: loads, word stores and trapped requests respond 1 cycle after accept; sub-word stores respond after 2 cycles.
// Backpressure: o_req_ready drops for the single RMW_WR cycle; a request presented then is ignored and must be held.
// Optional feature: define MAU_MISALIGN_TRAP_EN to trap misaligned half/word requests (resp_err=1, no memory access).
// Without it, the low address bits are forced to natural alignment and o_resp_err stays 0.

module mem_access_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_write,
  input  logic [1:0]            i_req_size,
  input  logic                  i_req_signed,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  input  logic [DATA_WIDTH-1:0] i_req_wdata,
  output logic                  o_resp_valid,
  output logic [DATA_WIDTH-1:0] o_resp_rdata,
  output logic                  o_resp_err,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_RMW_WR = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Captured sub-word store context, consumed in RMW_WR.
  logic [DATA_WIDTH-1:0] r_cap_old;
  logic [ADDR_WIDTH-1:0] r_cap_addr;
  logic                  r_cap_half;
  logic [15:0]           r_cap_wdata;

  // Registered response.
  logic                  r_resp_valid;
  logic [DATA_WIDTH-1:0] r_resp_rdata;
  logic                  r_resp_err;

  // Request decode. Size 2'b11 is reserved and behaves as a word.
  logic w_is_byte;
  logic w_is_half;
  logic w_is_word;
  logic w_err;
  logic [1:0] w_off;

  assign w_is_byte = (i_req_size == 2'b00);
  assign w_is_half = (i_req_size == 2'b01);
  assign w_is_word = i_req_size[1];

`ifdef MAU_MISALIGN_TRAP_EN
  logic w_misalign;
  assign w_misalign = (w_is_half & i_req_addr[0]) | (w_is_word & (|i_req_addr[1:0]));
  assign w_err      = w_misalign;
`else
  assign w_err      = 1'b0;
`endif

  // Byte offset of the selected lane; the unused low bits are dropped so
  // misaligned accesses snap to natural alignment.
  always_comb begin
    w_off = 2'b00;
    if (w_is_byte) begin
      w_off = i_req_addr[1:0];
    end else if (w_is_half) begin
      w_off = {i_req_addr[1], 1'b0};
    end
  end

  // Accept qualification per request class.
  logic w_accept;
  logic w_acc_load;
  logic w_acc_wst;
  logic w_acc_sst;
  logic w_acc_err;

  assign w_accept   = i_req_valid & (r_state == ST_IDLE);
  assign w_acc_load = w_accept & ~i_req_write & ~w_err;
  assign w_acc_wst  = w_accept &  i_req_write &  w_is_word & ~w_err;
  assign w_acc_sst  = w_accept &  i_req_write & ~w_is_word & ~w_err;
  assign w_acc_err  = w_accept &  w_err;

  // Load lane select and extension; memory read is combinational so the
  // result is ready in the accept cycle.
  logic [DATA_WIDTH-1:0] w_lane;
  logic [DATA_WIDTH-1:0] w_load_data;

  assign w_lane = i_mem_rdata >> {w_off, 3'b000};

  always_comb begin
    w_load_data = w_lane;
    if (w_is_byte) begin
      w_load_data = {{(DATA_WIDTH-8){i_req_signed & w_lane[7]}}, w_lane[7:0]};
    end else if (w_is_half) begin
      w_load_data = {{(DATA_WIDTH-16){i_req_signed & w_lane[15]}}, w_lane[15:0]};
    end
  end

  // Old word with the target lane replaced by the captured store data.
  logic [DATA_WIDTH-1:0] w_merged;

  always_comb begin
    w_merged = r_cap_old;
    if (r_cap_half) begin
      w_merged[{r_cap_addr[1], 4'b0000} +: 16] = r_cap_wdata;
    end else begin
      w_merged[{r_cap_addr[1:0], 3'b000} +: 8] = r_cap_wdata[7:0];
    end
  end

  // State register.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and combinational memory-side outputs; reset kills any write.
  always_comb begin
    w_state_nxt = r_state;
    o_req_ready = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_addr  = {2'b00, i_req_addr[ADDR_WIDTH-1:2]};
    o_mem_wdata = i_req_wdata;
    case (r_state)
      ST_IDLE: begin
        o_req_ready = 1'b1;
        if (w_acc_wst) begin
          o_mem_we = 1'b1;
        end
        if (w_acc_sst) begin
          w_state_nxt = ST_RMW_WR;
        end
      end
      ST_RMW_WR: begin
        o_mem_addr  = {2'b00, r_cap_addr[ADDR_WIDTH-1:2]};
        o_mem_wdata = w_merged;
        o_mem_we    = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    if (i_reset) begin
      o_mem_we = 1'b0;
    end
  end

  // Capture the old word and store context when a sub-word store is accepted.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_cap_old   <= '0;
      r_cap_addr  <= '0;
      r_cap_half  <= 1'b0;
      r_cap_wdata <= '0;
    end else if (w_acc_sst) begin
      r_cap_old   <= i_mem_rdata;
      r_cap_addr  <= i_req_addr;
      r_cap_half  <= w_is_half;
      r_cap_wdata <= i_req_wdata[15:0];
    end
  end

  // Response register: one pulse per accepted request; sub-word stores respond after RMW_WR.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
    end else begin
      r_resp_valid <= (w_accept & ~w_acc_sst) | (r_state == ST_RMW_WR);
      r_resp_rdata <= w_acc_load ? w_load_data : '0;
      r_resp_err   <= w_acc_err;
    end
  end

  assign o_resp_valid = r_resp_valid;
  assign o_resp_rdata = r_resp_rdata;
  assign o_resp_err   = r_resp_err;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: word memory model, response scoreboard with
// expected completion cycle, a vector table, and hand-written RMW/reset sequences.
// Honours MAU_MISALIGN_TRAP_EN to select the misaligned-access expectations.

module tb_mem_access_unit;

`ifdef MAU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .i_clock      (clk),
    .i_reset      (rst),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_req_write  (req_write),
    .i_req_size   (req_size),
    .i_req_signed (req_signed),
    .i_req_addr   (req_addr),
    .i_req_wdata  (req_wdata),
    .o_resp_valid (resp_valid),
    .o_resp_rdata (resp_rdata),
    .o_resp_err   (resp_err),
    .o_mem_we     (mem_we),
    .o_mem_addr   (mem_addr),
    .o_mem_wdata  (mem_wdata),
    .i_mem_rdata  (mem_rdata)
  );

  // data_memory model: combinational read, write on posedge.
  logic [31:0] mem [0:63];
  logic        mem_clr;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
    end else if (mem_we) begin
      mem[mem_addr[5:0]] <= mem_wdata;
    end
  end

  assign mem_rdata = mem[mem_addr[5:0]];

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    logic        w;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] er;
    logic        ee;
    int          lat;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Response monitor: every pulse must match the oldest outstanding request.
  exp_t mon_e;
  always @(negedge clk) begin
    if (resp_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got resp_valid=1 rdata=0x%08h, expected no response (cycle %0d)", resp_rdata, cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("resp_rdata", resp_rdata, mon_e.rdata);
        chk("resp_err", 32'(resp_err), 32'(mon_e.err));
        chk("resp_cycle", 32'(cyc), 32'(mon_e.due));
      end
    end
  end

  // Drive a request at a negedge once ready, recording its expected response.
  task automatic drive(input logic w, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] er, input logic ee, input int lat);
    int n = 0;
    while (!req_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_wait", 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_write  = w;
    req_size   = sz;
    req_signed = sg;
    req_addr   = a;
    req_wdata  = wd;
    sb.push_back('{er, ee, cyc + lat});
  endtask

  task automatic issue(input vec_t v);
    drive(v.w, v.sz, v.sg, v.a, v.wd, v.er, v.ee, v.lat);
    @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    req_valid = 1'b0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("drain_outstanding", 32'(sb.size()), 32'd0);
  endtask

  logic [31:0] b2b_addr [3];
  logic [31:0] b2b_exp  [3];

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with a word store presented: nothing may be written.
    rst = 1'b1; mem_clr = 1'b1;
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_signed = 1'b0;
    req_addr = 32'h10; req_wdata = 32'hFFFF_FFFF;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    rst = 1'b0; mem_clr = 1'b0; req_valid = 1'b0;
    @(negedge clk);

    // Word store then word load of the same address.
    drive(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1);
    #1;
    chk("wst_mem_we", 32'(mem_we), 32'd1);
    chk("wst_mem_addr", mem_addr, 32'd4);
    chk("wst_mem_wdata", mem_wdata, 32'hDEADBEEF);
    @(negedge clk);
    drive(1'b0, 2'b10, 1'b1, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1);
    #1;
    chk("ld_mem_we", 32'(mem_we), 32'd0);
    chk("ld_mem_addr", mem_addr, 32'd4);
    @(negedge clk);
    drain();

    // Preload words 0 and 4.
    issue('{1'b1, 2'b10, 1'b0, 32'h0,  32'h8000FF80, 32'h0, 1'b0, 1});
    issue('{1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, 32'h0, 1'b0, 1});
    drain();

    // Byte RMW store; the request stays presented through RMW_WR and is ignored.
    drive(1'b1, 2'b00, 1'b0, 32'h12, 32'h000000AA, 32'h0, 1'b0, 2);
    #1;
    chk("rmw_acc_mem_we", 32'(mem_we), 32'd0);
    @(negedge clk);
    #1;
    chk("rmw_req_ready", 32'(req_ready), 32'd0);
    chk("rmw_mem_we", 32'(mem_we), 32'd1);
    chk("rmw_mem_addr", mem_addr, 32'd4);
    chk("rmw_mem_wdata", mem_wdata, 32'h11AA3344);
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    chk("rmw_ready_back", 32'(req_ready), 32'd1);
    chk("rmw_mem_word4", mem[4], 32'h11AA3344);
    drain();

    // Vector table, applied back-to-back.
    vt.push_back('{1'b0, 2'b00, 1'b1, 32'h00, 32'h0, 32'hFFFFFF80, 1'b0, 1});
    vt.push_back('{1'b0, 2'b00, 1'b0, 32'h00, 32'h0, 32'h00000080, 1'b0, 1});
    vt.push_back('{1'b0, 2'b01, 1'b1, 32'h02, 32'h0, 32'hFFFF8000, 1'b0, 1});
    vt.push_back('{1'b0, 2'b01, 1'b0, 32'h02, 32'h0, 32'h00008000, 1'b0, 1});
    vt.push_back('{1'b0, 2'b00, 1'b1, 32'h01, 32'h0, 32'hFFFFFFFF, 1'b0, 1});
    vt.push_back('{1'b0, 2'b01, 1'b1, 32'h00, 32'h0, 32'hFFFFFF80, 1'b0, 1});
    vt.push_back('{1'b0, 2'b00, 1'b0, 32'h03, 32'h0, 32'h00000080, 1'b0, 1});
    vt.push_back('{1'b1, 2'b01, 1'b0, 32'h22, 32'hFFFF1234, 32'h0, 1'b0, 2});
    vt.push_back('{1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h12340000, 1'b0, 1});
    vt.push_back('{1'b1, 2'b00, 1'b0, 32'h21, 32'h1234565A, 32'h0, 1'b0, 2});
    vt.push_back('{1'b0, 2'b10, 1'b1, 32'h20, 32'h0, 32'h12345A00, 1'b0, 1});
    vt.push_back('{1'b0, 2'b10, 1'b0, 32'h13, 32'h0, TRAP ? 32'h0 : 32'h11AA3344, TRAP, 1});
    vt.push_back('{1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 32'h11AA3344, 1'b0, 1});
    vt.push_back('{1'b0, 2'b01, 1'b1, 32'h23, 32'h0, TRAP ? 32'h0 : 32'h00001234, TRAP, 1});
    vt.push_back('{1'b1, 2'b10, 1'b0, 32'h24, 32'hCAFEF00D, 32'h0, 1'b0, 1});
    vt.push_back('{1'b0, 2'b00, 1'b0, 32'h27, 32'h0, 32'h000000CA, 1'b0, 1});
    vt.push_back('{1'b0, 2'b00, 1'b1, 32'h27, 32'h0, 32'hFFFFFFCA, 1'b0, 1});
    vt.push_back('{1'b1, 2'b10, 1'b0, 32'h25, 32'h0, 32'h0, TRAP, 1});
    vt.push_back('{1'b0, 2'b10, 1'b0, 32'h24, 32'h0, TRAP ? 32'hCAFEF00D : 32'h0, 1'b0, 1});
    vt.push_back('{1'b1, 2'b01, 1'b0, 32'h21, 32'h0000BEEF, 32'h0, TRAP, TRAP ? 1 : 2});
    vt.push_back('{1'b0, 2'b10, 1'b0, 32'h20, 32'h0, TRAP ? 32'h12345A00 : 32'h1234BEEF, 1'b0, 1});
    vt.push_back('{1'b1, 2'b10, 1'b0, 32'h28, 32'h0BADF00D, 32'h0, 1'b0, 1});
    vt.push_back('{1'b0, 2'b10, 1'b0, 32'h28, 32'h0, 32'h0BADF00D, 1'b0, 1});
    for (int i = 0; i < vt.size(); i++) begin
      issue(vt[i]);
    end
    drain();

    // Misaligned word store: trapped means no write strobe.
    drive(1'b1, 2'b10, 1'b0, 32'h25, 32'h55555555, 32'h0, TRAP, 1);
    #1;
    chk("mis_wst_mem_we", 32'(mem_we), TRAP ? 32'd0 : 32'd1);
    @(negedge clk);
    drain();

    // Three back-to-back word loads.
    b2b_addr[0] = 32'h00; b2b_exp[0] = 32'h8000FF80;
    b2b_addr[1] = 32'h10; b2b_exp[1] = 32'h11AA3344;
    b2b_addr[2] = 32'h28; b2b_exp[2] = 32'h0BADF00D;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 2'b10, 1'b0, b2b_addr[i], 32'h0, b2b_exp[i], 1'b0, 1);
      #1;
      chk("b2b_req_ready", 32'(req_ready), 32'd1);
      @(negedge clk);
    end
    drain();

    // Reset during RMW_WR drops the write and the response.
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b01; req_signed = 1'b0;
    req_addr = 32'h2; req_wdata = 32'h0000BEEF;
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    chk("rstrmw_req_ready", 32'(req_ready), 32'd0);
    chk("rstrmw_mem_wdata", mem_wdata, 32'hBEEFFF80);
    rst = 1'b1;
    #1;
    chk("rstrmw_mem_we", 32'(mem_we), 32'd0);
    @(negedge clk);
    chk("rstrmw_resp_valid", 32'(resp_valid), 32'd0);
    rst = 1'b0;
    #1;
    chk("rstrmw_ready_after", 32'(req_ready), 32'd1);
    chk("rstrmw_word0", mem[0], 32'h8000FF80);
    repeat (3) @(negedge clk);
    chk("rstrmw_no_resp", 32'(resp_valid), 32'd0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
